// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared constants for the bit-serial adder.
// Holds the FSM state encoding, the default operand width and a sizing helper.
package serial_adder_pkg;

  // Default operand/result width; legal range is 2..32.
  localparam int DEF_WIDTH = 8;

  // FSM state encoding.
  localparam int         STATE_W  = 2;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Width of the bit counter: it only has to reach WIDTH-1.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage : serial_adder_pkg

// File: rtl/serial_adder_adder.sv
// adder: the existing 1-bit full adder stage fed by the serial sequencer.
// Purely combinational: Sum/Cout of A + B + Cin.
module adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule : adder

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, one bit per clock, LSB first.
// Operands are captured into shift registers on an accepted start; a single
// full-adder stage processes bit 0 of each while the carry lives in a flop.
// After WIDTH cycles the assembled result is latched into sum/cout and done
// pulses for one cycle. A start in the DONE cycle is accepted without a bubble.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  // Elaboration-time guard on the supported width range.
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("serial_adder: WIDTH must be in 2..32");
  end

  // Control state and registered outputs.
  logic [STATE_W-1:0] r_state;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;

  // Serial datapath: operand shifters, partial result, carry and bit count.
  // The result shifter keeps only WIDTH-1 bits; the final bit comes straight
  // from the adder on the last cycle.
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [WIDTH-2:0]   r_res_sh;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_sum_bit;
  logic               w_cout_bit;
  logic               w_run;
  logic               w_last;
  logic               w_accept;
  logic [WIDTH-1:0]   w_res_next;

  assign w_run      = (r_state == ST_RUN);
  assign w_last     = w_run && (r_cnt == LAST_BIT);
  // Start is honoured only when no add is in flight (IDLE or the DONE cycle).
  assign w_accept   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  // New bit enters at the MSB; after WIDTH shifts bit 0 lands at position 0.
  assign w_res_next = {w_sum_bit, r_res_sh};

  adder u_fa (
    .A    (r_a_sh[0]),
    .B    (r_b_sh[0]),
    .Cin  (r_carry),
    .Sum  (w_sum_bit),
    .Cout (w_cout_bit)
  );

  // FSM with registered busy/done and the result registers that update only at completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_last) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_sum   <= w_res_next;
            r_cout  <= w_cout_bit;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Operand capture on accept, then one bit shifted through the full adder per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res_sh <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_a_sh  <= a;
      r_b_sh  <= b;
      r_carry <= cin;
      r_cnt   <= '0;
    end else if (w_run) begin
      r_a_sh   <= r_a_sh >> 1;
      r_b_sh   <= r_b_sh >> 1;
      r_res_sh <= w_res_next[WIDTH-1:1];
      r_carry  <= w_cout_bit;
      // Hold at the last index so the counter never wraps.
      if (!w_last) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed, table-driven bench for serial_adder (WIDTH=8)
// plus an exhaustive sweep of a WIDTH=4 instance.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;

  logic       start8;
  logic [7:0] a8, b8;
  logic       cin8;
  logic       busy8, done8;
  logic [7:0] sum8;
  logic       cout8;

  logic       start4;
  logic [3:0] a4, b4;
  logic       cin4;
  logic       busy4, done4;
  logic [3:0] sum4;
  logic       cout4;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .cin   (cin4),
    .busy  (busy4),
    .done  (done4),
    .sum   (sum4),
    .cout  (cout4)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  vec_t       vecs[10];
  int         n_checks = 0;
  int         n_err    = 0;
  logic [7:0] prev_sum  = 8'h00;
  logic       prev_cout = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Called at a negedge; issues one add and checks latency, hold and result.
  task automatic run_add(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                         input logic [7:0] es, input logic ec, input string nm);
    int n;
    a8 = ta; b8 = tb_v; cin8 = tc; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    n = 0;
    chk({nm, ".busy"}, {31'd0, busy8}, 32'd1);
    while (done8 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 4) chk({nm, ".hold"}, {23'd0, cout8, sum8}, {23'd0, prev_cout, prev_sum});
    end
    chk({nm, ".latency"}, n, 32'd8);
    chk({nm, ".sum"}, {24'd0, sum8}, {24'd0, es});
    chk({nm, ".cout"}, {31'd0, cout8}, {31'd0, ec});
    @(negedge clk);
    chk({nm, ".done_pulse"}, {31'd0, done8}, 32'd0);
    prev_sum  = es;
    prev_cout = ec;
  endtask

  logic [7:0] bb_a[3];
  logic [7:0] bb_b[3];
  logic       bb_c[3];
  logic [7:0] bb_s[3];
  logic       bb_o[3];

  initial begin
    int busy_cnt, done_cnt, ndone, last, cnt;
    logic [7:0] got_sum;
    logic       got_cout;

    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;

    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    vecs[3] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0};
    vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[7] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vecs[8] = '{8'hC8, 8'h64, 1'b1, 8'h2D, 1'b1};
    vecs[9] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0};

    // Reset values before any stimulus.
    #1;
    chk("reset.busy", {31'd0, busy8}, 32'd0);
    chk("reset.done", {31'd0, done8}, 32'd0);
    chk("reset.sum",  {24'd0, sum8},  32'd0);
    chk("reset.cout", {31'd0, cout8}, 32'd0);
    chk("reset4.out", {26'd0, busy4, done4, cout4, sum4}, 32'd0);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven single adds.
    for (int i = 0; i < 10; i++) begin
      run_add(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout,
              $sformatf("vec%0d", i));
    end

    // start held while busy, operands changed mid-RUN.
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    busy_cnt = 0; done_cnt = 0; got_sum = 8'h00; got_cout = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 3) begin a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; end
      if (i == 6) start8 = 1'b0;
      busy_cnt += int'(busy8);
      if (done8 === 1'b1) begin
        done_cnt++;
        got_sum  = sum8;
        got_cout = cout8;
      end
    end
    chk("hold.busy_cycles", busy_cnt, 32'd8);
    chk("hold.done_count",  done_cnt, 32'd1);
    chk("hold.sum",  {24'd0, got_sum},  32'h46);
    chk("hold.cout", {31'd0, got_cout}, 32'd0);
    prev_sum = 8'h46; prev_cout = 1'b0;

    // Back-to-back adds with start held high.
    bb_a[0] = 8'h11; bb_b[0] = 8'h22; bb_c[0] = 1'b0; bb_s[0] = 8'h33; bb_o[0] = 1'b0;
    bb_a[1] = 8'hF0; bb_b[1] = 8'h0F; bb_c[1] = 1'b1; bb_s[1] = 8'h00; bb_o[1] = 1'b1;
    bb_a[2] = 8'h80; bb_b[2] = 8'h7F; bb_c[2] = 1'b0; bb_s[2] = 8'hFF; bb_o[2] = 1'b0;
    a8 = bb_a[0]; b8 = bb_b[0]; cin8 = bb_c[0]; start8 = 1'b1;
    ndone = 0; last = 0;
    for (int i = 0; i < 40 && ndone < 3; i++) begin
      @(negedge clk);
      if (done8 === 1'b1) begin
        chk($sformatf("b2b%0d.sum", ndone),  {24'd0, sum8},  {24'd0, bb_s[ndone]});
        chk($sformatf("b2b%0d.cout", ndone), {31'd0, cout8}, {31'd0, bb_o[ndone]});
        if (ndone == 0) chk("b2b.first_latency", i, 32'd8);
        else            chk($sformatf("b2b%0d.spacing", ndone), i - last, 32'd9);
        last = i;
        ndone++;
        if (ndone < 3) begin
          a8 = bb_a[ndone]; b8 = bb_b[ndone]; cin8 = bb_c[ndone];
        end else begin
          start8 = 1'b0;
        end
      end else if (i == 0 || i == 9 || i == 18) begin
        a8 = 8'h5A; b8 = 8'hC3; cin8 = 1'b1;
      end
    end
    chk("b2b.count", ndone, 32'd3);
    start8 = 1'b0;
    @(negedge clk);
    prev_sum = 8'hFF; prev_cout = 1'b0;

    // Reset in the middle of an add.
    a8 = 8'h3C; b8 = 8'h0F; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort.busy", {31'd0, busy8}, 32'd0);
    chk("abort.done", {31'd0, done8}, 32'd0);
    chk("abort.sum",  {24'd0, sum8},  32'd0);
    chk("abort.cout", {31'd0, cout8}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      cnt += int'(done8) + int'(busy8);
    end
    chk("abort.no_done", cnt, 32'd0);
    prev_sum = 8'h00; prev_cout = 1'b0;
    run_add(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, "post_reset");

    // WIDTH=4 exhaustive sweep against a+b+cin.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          int n;
          logic [4:0] exp5;
          exp5 = 5'(ia) + 5'(ib) + 5'(ic);
          a4 = 4'(ia); b4 = 4'(ib); cin4 = 1'(ic); start4 = 1'b1;
          @(negedge clk);
          start4 = 1'b0;
          n = 0;
          while (done4 !== 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
          end
          chk($sformatf("w4.lat a=%0h b=%0h c=%0d", ia, ib, ic), n, 32'd4);
          chk($sformatf("w4.res a=%0h b=%0h c=%0d", ia, ib, ic),
              {27'd0, cout4, sum4}, {27'd0, exp5});
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_serial_adder
